// File: rtl/score_stream_sequencer_if.sv
// Database-base stream into the sequencer.
// Producer drives valid/base/last/id; the sequencer answers with ready.
interface score_stream_sequencer_if #(
  parameter int ID_WIDTH = 8
) ();
  logic                s_valid;
  logic                s_ready;
  logic [1:0]          s_base;
  logic                s_last;
  logic [ID_WIDTH-1:0] s_id;

  modport master (
    output s_valid, s_base, s_last, s_id,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_base, s_last, s_id,
    output s_ready
  );
endinterface

// File: rtl/score_stream_sequencer.sv
// Query loader / db streamer / result tagger for the ScoringModule array.
// Optional SEQ_STATS_EN adds best-score and sequence-count outputs.
module score_stream_sequencer #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 48,
  parameter logic [SCORE_WIDTH-1:0] ZERO =
    {1'b1, {(SCORE_WIDTH-1){1'b0}}},
  parameter int ID_WIDTH    = 8,
  parameter int INFLIGHT    = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_start,
  input  logic                    q_wr,
  input  logic [1:0]              q_base,
  input  logic                    q_end,
  score_stream_sequencer_if.slave s,
  output logic                    sm_en,
  output logic [1:0]              sm_data,
  output logic [2*LENGTH-1:0]     sm_query,
  output logic [6:0]              sm_qlen,
  input  logic [SCORE_WIDTH-1:0]  sm_result,
  input  logic                    sm_vld,
  output logic                    r_valid,
  output logic [SCORE_WIDTH-1:0]  r_score,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic                    busy,
`ifdef SEQ_STATS_EN
  output logic [SCORE_WIDTH-1:0]  best_score,
  output logic [ID_WIDTH-1:0]     best_id,
  output logic [15:0]             seq_count,
`endif
  output logic                    err_orphan
);

  localparam int AW = $clog2(INFLIGHT);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(INFLIGHT);

  typedef enum logic [2:0] {
    IDLE, LOAD_Q, STREAM, GAP, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  first_q;
  logic [GW-1:0]         gcnt_q;
  logic [6:0]            qcnt_q, qn;
  logic [2*LENGTH-1:0]   query_q, query_d;
  logic [6:0]            qlen_q;
  logic                  en_q;
  logic [1:0]            data_q;
  logic [ID_WIDTH-1:0]   fifo_q [INFLIGHT];
  logic [CW-1:0]         wp_q, rp_q, cnt_q;
  logic                  vld_q, rv_q, orphan_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [SCORE_WIDTH-1:0] rsc_q;

  logic qclr, sclr, rdy, accept, push, rise, pop, wr_ok, full;

  assign full   = (cnt_q == FULL);
  assign accept = s.s_valid & rdy;
  assign push   = accept & first_q;
  assign rise   = sm_vld & ~vld_q;
  assign pop    = rise & (cnt_q != '0);
  assign wr_ok  = (state_q == LOAD_Q) & q_wr;
  assign qn     = (qcnt_q < 7'(LENGTH)) ? qcnt_q + 7'd1 : qcnt_q;

  always_comb begin
    state_d = state_q;
    qclr    = 1'b0;
    sclr    = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      IDLE: if (q_start) begin
        sclr = 1'b1;
        if (cnt_q == '0) begin
          state_d = LOAD_Q;
          qclr    = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      LOAD_Q: if (q_wr & q_end) state_d = STREAM;
      // q_start only takes effect between sequences
      STREAM: if (q_start & first_q) begin
        state_d = DRAIN;
        sclr    = 1'b1;
      end else begin
        rdy = ~full | ~first_q;
        if (s.s_valid & rdy & s.s_last & (GAP_CYCLES > 0))
          state_d = GAP;
      end
      GAP: if (gcnt_q == GMAX) state_d = STREAM;
      DRAIN: if (cnt_q == '0) begin
        state_d = LOAD_Q;
        qclr    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    query_d = query_q;
    if (qclr) begin
      query_d = '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LENGTH; i++)
        if (qcnt_q == 7'(i)) query_d[2*i +: 2] = q_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      first_q  <= 1'b1;
      gcnt_q   <= '0;
      qcnt_q   <= '0;
      query_q  <= '0;
      qlen_q   <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      for (int i = 0; i < INFLIGHT; i++) fifo_q[i] <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      rv_q     <= 1'b0;
      rid_q    <= '0;
      rsc_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      query_q <= query_d;
      gcnt_q  <= (state_q == GAP) ? gcnt_q + GW'(1) : '0;
      if (qclr) begin
        qcnt_q <= '0;
      end else if (wr_ok) begin
        qcnt_q <= qn;
        if (q_end) qlen_q <= qn - 7'd1;
      end
      en_q   <= accept;
      data_q <= accept ? s.s_base : 2'b00;
      if (accept) first_q <= s.s_last;
      if (push) begin
        fifo_q[wp_q[AW-1:0]] <= s.s_id;
        wp_q <= wp_q + CW'(1);
      end
      vld_q <= sm_vld;
      rv_q  <= pop;
      if (pop) begin
        rid_q <= fifo_q[rp_q[AW-1:0]];
        rsc_q <= sm_result - ZERO;
        rp_q  <= rp_q + CW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (rise & (cnt_q == '0)) orphan_q <= 1'b1;
    end
  end

  assign s.s_ready  = rdy;
  assign sm_en      = en_q;
  assign sm_data    = data_q;
  assign sm_query   = query_q;
  assign sm_qlen    = qlen_q;
  assign r_valid    = rv_q;
  assign r_score    = rsc_q;
  assign r_id       = rid_q;
  assign busy       = (state_q != IDLE) | (cnt_q != '0);
  assign err_orphan = orphan_q;

`ifdef SEQ_STATS_EN
  logic [SCORE_WIDTH-1:0] best_q;
  logic [ID_WIDTH-1:0]    bid_q;
  logic [15:0]            scnt_q;

  // scores are signed; first result of a run always seeds the best
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q <= '0;
      bid_q  <= '0;
      scnt_q <= '0;
    end else if (sclr) begin
      best_q <= '0;
      bid_q  <= '0;
      scnt_q <= '0;
    end else if (rv_q) begin
      if (scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
      if ((scnt_q == 16'd0) ||
          ($signed(rsc_q) > $signed(best_q))) begin
        best_q <= rsc_q;
        bid_q  <= rid_q;
      end
    end
  end

  assign best_score = best_q;
  assign best_id    = bid_q;
  assign seq_count  = scnt_q;
`endif

endmodule

// File: tb/tb_score_stream_sequencer.sv
// Directed bench for score_stream_sequencer.
// Build with SEQ_STATS_EN defined to also cover the statistics outputs.
module tb_score_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        q_start = 1'b0;
  logic        q_wr = 1'b0;
  logic [1:0]  q_base = 2'b00;
  logic        q_end = 1'b0;
  logic        sm_en;
  logic [1:0]  sm_data;
  logic [95:0] sm_query;
  logic [6:0]  sm_qlen;
  logic [11:0] sm_result = 12'h000;
  logic        sm_vld = 1'b0;
  logic        r_valid;
  logic [11:0] r_score;
  logic [7:0]  r_id;
  logic        busy;
  logic        err_orphan;
`ifdef SEQ_STATS_EN
  logic [11:0] best_score;
  logic [7:0]  best_id;
  logic [15:0] seq_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0]  en_log[$];
  logic [7:0]  rid_log[$];
  logic [11:0] rsc_log[$];

  score_stream_sequencer_if #(.ID_WIDTH(8)) sif ();

  score_stream_sequencer dut (
    .clk(clk), .rst(rst),
    .q_start(q_start), .q_wr(q_wr),
    .q_base(q_base), .q_end(q_end),
    .s(sif),
    .sm_en(sm_en), .sm_data(sm_data),
    .sm_query(sm_query), .sm_qlen(sm_qlen),
    .sm_result(sm_result), .sm_vld(sm_vld),
    .r_valid(r_valid), .r_score(r_score),
    .r_id(r_id), .busy(busy),
`ifdef SEQ_STATS_EN
    .best_score(best_score), .best_id(best_id),
    .seq_count(seq_count),
`endif
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    en_log.push_back({sm_en, sm_data});
    if (r_valid) begin
      rid_log.push_back(r_id);
      rsc_log.push_back(r_score);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_logs();
    en_log.delete();
    rid_log.delete();
    rsc_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q_start = 0; q_wr = 0; q_end = 0; q_base = 0;
    sm_vld = 0; sm_result = 0;
    sif.s_valid = 0; sif.s_base = 0;
    sif.s_last = 0; sif.s_id = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_qstart();
    @(negedge clk) q_start = 1'b1;
    @(negedge clk) q_start = 1'b0;
  endtask

  task automatic write_q(input int n, input logic [127:0] b);
    for (int i = 0; i < n; i++) begin
      q_wr = 1'b1;
      q_base = b[2*i +: 2];
      q_end = (i == n - 1);
      @(negedge clk);
    end
    q_wr = 1'b0;
    q_end = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (sif.s_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: s_ready=%b required 1", sif.s_ready);
    end
  endtask

  task automatic send_seq(input logic [7:0] id, input int n,
                          input logic [127:0] b);
    for (int i = 0; i < n; i++) begin
      sif.s_valid = 1'b1;
      sif.s_base = b[2*i +: 2];
      sif.s_last = (i == n - 1);
      sif.s_id = id;
      wait_ready();
      @(negedge clk);
    end
  endtask

  task automatic stop_stream();
    sif.s_valid = 1'b0;
    sif.s_last = 1'b0;
  endtask

  task automatic pulse_vld(input int score);
    @(negedge clk);
    sm_result = 12'h800 + 12'(score);
    sm_vld = 1'b1;
    @(negedge clk) sm_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({sm_en, r_valid, busy, err_orphan, sif.s_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 00000",
               {sm_en, r_valid, busy, err_orphan, sif.s_ready});
    end
    n_cmp++;
    if ({sm_query, sm_qlen, sm_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_query: query=%h qlen=%0d required 0",
               sm_query, sm_qlen);
    end
    n_cmp++;
    if ({r_score, r_id} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_result: score=%h id=%h required 0",
               r_score, r_id);
    end
`ifdef SEQ_STATS_EN
    n_cmp++;
    if ({best_score, best_id, seq_count} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_stats: %h required 0",
               {best_score, best_id, seq_count});
    end
`endif
  endtask

  task automatic test_single();
    int ne;
    logic [7:0] dat;
    pulse_qstart();
    write_q(4, 128'h9C);
    n_cmp++;
    if (sm_qlen !== 7'd3) begin
      n_bad++;
      $display("FAIL acgt_qlen: got %0d required 3", sm_qlen);
    end
    n_cmp++;
    if (sm_query !== 96'h9C) begin
      n_bad++;
      $display("FAIL acgt_query: got %h required 9c", sm_query);
    end
    clr_logs();
    send_seq(8'd3, 4, 128'h9C);
    stop_stream();
    repeat (3) @(negedge clk);
    ne = 0;
    dat = 8'h00;
    foreach (en_log[k]) if (en_log[k][2]) begin
      ne++;
      dat = {dat[5:0], en_log[k][1:0]};
    end
    n_cmp++;
    if (ne != 4) begin
      n_bad++;
      $display("FAIL acgt_en_cycles: got %0d required 4", ne);
    end
    n_cmp++;
    if (dat !== 8'h36) begin
      n_bad++;
      $display("FAIL acgt_data: got %h required 36", dat);
    end
    pulse_vld(20);
    @(negedge clk);
    n_cmp++;
    if (rid_log.size() != 1) begin
      n_bad++;
      $display("FAIL acgt_rcount: got %0d required 1", rid_log.size());
    end else begin
      n_cmp++;
      if ({rid_log[0], rsc_log[0]} !== {8'd3, 12'd20}) begin
        n_bad++;
        $display("FAIL acgt_result: id=%0d score=%0d required id=3 score=20",
                 rid_log[0], rsc_log[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] pat;
    logic [23:0] ids;
    clr_logs();
    send_seq(8'd1, 2, 128'h6);
    send_seq(8'd2, 2, 128'h6);
    send_seq(8'd3, 2, 128'h6);
    stop_stream();
    repeat (3) @(negedge clk);
    k = 0;
    while (k < en_log.size() && !en_log[k][2]) k++;
    pat = 8'h00;
    for (int j = 0; j < 8; j++)
      pat = {pat[6:0], (k + j < en_log.size()) ? en_log[k+j][2] : 1'b0};
    n_cmp++;
    if (pat !== 8'b1101_1011) begin
      n_bad++;
      $display("FAIL b2b_gap_pattern: got %b required 11011011", pat);
    end
    pulse_vld(1);
    pulse_vld(2);
    pulse_vld(3);
    @(negedge clk);
    ids = 24'h0;
    foreach (rid_log[i]) ids = {ids[15:0], rid_log[i]};
    n_cmp++;
    if (rid_log.size() != 3 || ids !== 24'h010203) begin
      n_bad++;
      $display("FAIL b2b_id_order: got n=%0d ids=%h required 010203",
               rid_log.size(), ids);
    end
  endtask

  task automatic test_fifo_full();
    logic saw;
    clr_logs();
    send_seq(8'd10, 1, 128'h0);
    send_seq(8'd11, 1, 128'h1);
    send_seq(8'd12, 1, 128'h2);
    send_seq(8'd13, 1, 128'h3);
    sif.s_valid = 1'b1;
    sif.s_base = 2'b01;
    sif.s_last = 1'b1;
    sif.s_id = 8'd14;
    saw = sif.s_ready;
    repeat (4) begin
      @(negedge clk);
      saw |= sif.s_ready;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_bad++;
      $display("FAIL full_block: s_ready=%b required 0", saw);
    end
    sm_result = 12'h801;
    sm_vld = 1'b1;
    @(negedge clk) sm_vld = 1'b0;
    n_cmp++;
    if (sif.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_release: s_ready=%b required 1", sif.s_ready);
    end
    @(negedge clk);
    stop_stream();
    @(negedge clk);
    n_cmp++;
    if (rid_log.size() != 1 || rid_log[0] !== 8'd10) begin
      n_bad++;
      $display("FAIL full_pop_id: n=%0d required id 10", rid_log.size());
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL full_busy: got %b required 1", busy);
    end
  endtask

  task automatic test_drain();
    logic [127:0] b;
    logic [95:0]  exq;
    pulse_vld(5);
    pulse_vld(6);
    repeat (2) @(negedge clk);
    pulse_qstart();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sm_query !== 96'h9C || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_hold: query=%h busy=%b required 9c/1",
               sm_query, busy);
    end
    clr_logs();
    pulse_vld(7);
    pulse_vld(8);
    n_cmp++;
    if (rid_log.size() != 2 || {rid_log[0], rid_log[1]} !== {8'd13, 8'd14}) begin
      n_bad++;
      $display("FAIL drain_ids: n=%0d required ids 13,14", rid_log.size());
    end
    @(negedge clk);
    n_cmp++;
    if (sm_query !== 96'h0) begin
      n_bad++;
      $display("FAIL loadq_clear: got %h required 0", sm_query);
    end
    b = '0;
    exq = '0;
    for (int i = 0; i < 64; i++) b[2*i +: 2] = 2'(i);
    for (int i = 0; i < 48; i++) exq[2*i +: 2] = 2'(i);
    write_q(60, b);
    @(negedge clk);
    n_cmp++;
    if (sm_qlen !== 7'd47) begin
      n_bad++;
      $display("FAIL qlen_sat: got %0d required 47", sm_qlen);
    end
    n_cmp++;
    if (sm_query !== exq) begin
      n_bad++;
      $display("FAIL query_sat: got %h required %h", sm_query, exq);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    clr_logs();
    pulse_vld(9);
    @(negedge clk);
    n_cmp++;
    if (rid_log.size() != 0) begin
      n_bad++;
      $display("FAIL orphan_rvalid: got %0d pulses required 0",
               rid_log.size());
    end
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan_flag: got %b required 1", err_orphan);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan_sticky: got %b required 1", err_orphan);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_qstart();
    write_q(4, 128'h9C);
    sif.s_valid = 1'b1;
    sif.s_base = 2'b01;
    sif.s_last = 1'b0;
    sif.s_id = 8'd9;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sm_en, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_active: en/busy=%b required 11", {sm_en, busy});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({sm_en, busy, sif.s_ready, err_orphan} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset: en/busy/rdy/orph=%b required 0000",
               {sm_en, busy, sif.s_ready, err_orphan});
    end
    n_cmp++;
    if (sm_query !== 96'h0) begin
      n_bad++;
      $display("FAIL mid_reset_query: got %h required 0", sm_query);
    end
    stop_stream();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    clr_logs();
    pulse_vld(4);
    @(negedge clk);
    n_cmp++;
    if ({err_orphan, 1'b0} !== 2'b10 || rid_log.size() != 0) begin
      n_bad++;
      $display("FAIL mid_fifo_empty: orphan=%b pulses=%0d required 1/0",
               err_orphan, rid_log.size());
    end
  endtask

`ifdef SEQ_STATS_EN
  task automatic test_stats();
    do_reset();
    pulse_qstart();
    write_q(4, 128'h9C);
    send_seq(8'd4, 1, 128'h0);
    send_seq(8'd5, 1, 128'h1);
    send_seq(8'd6, 1, 128'h2);
    stop_stream();
    pulse_vld(7);
    pulse_vld(20);
    pulse_vld(20);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (best_score !== 12'd20 || best_id !== 8'd5) begin
      n_bad++;
      $display("FAIL stats_best: score=%0d id=%0d required 20/5",
               best_score, best_id);
    end
    n_cmp++;
    if (seq_count !== 16'd3) begin
      n_bad++;
      $display("FAIL stats_count: got %0d required 3", seq_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_drain();
    test_orphan();
    test_reset_mid();
`ifdef SEQ_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
